// File: rtl/w0rm_core_mem_stage.sv
// ============================================================================
// Module   : w0rm_core_mem_stage
// Brief    : W0RM memory stage with sub-word access, pop post-increment,
//            bus timeout and ready/valid result handshake.
// Revision : 2.0
// ============================================================================
`default_nettype none

module w0rm_core_mem_stage #(
    parameter int USER_WIDTH     = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid_i,
    output logic                      mem_ready,
    input  logic                      mem_write,
    input  logic                      mem_read,
    input  logic                      mem_is_pop,
    input  logic                      mem_signed,
    input  logic [1:0]                mem_size,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic [USER_WIDTH-1:0]     user_data_in,
    output logic                      mem_output_valid,
    input  logic                      mem_out_ready,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic [ADDR_WIDTH-1:0]     mem_addr_out,
    output logic                      mem_error,
    output logic [USER_WIDTH-1:0]     user_data_out,
    output logic                      data_bus_valid_out,
    output logic                      data_bus_write_out,
    output logic                      data_bus_read_out,
    output logic [ADDR_WIDTH-1:0]     data_bus_addr_out,
    output logic [DATA_WIDTH-1:0]     data_bus_data_out,
    output logic [DATA_WIDTH/8-1:0]   data_bus_strobe_out,
    input  logic [DATA_WIDTH-1:0]     data_bus_data_in,
    input  logic                      data_bus_valid_in
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(STRB_WIDTH);
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0]           c_STRB_BYTES = 4'(STRB_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_TMO_LAST   =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_tmo_cnt;
    logic                   r_write;
    logic                   r_signed;
    logic [1:0]             r_size;
    logic [LANE_BITS-1:0]   r_lane;
    logic [ADDR_WIDTH-1:0]  r_res_addr;
    logic [USER_WIDTH-1:0]  r_user;

    // Request-side decode, taken straight from the inputs at accept time
    logic [3:0]             w_in_bytes;
    logic [2:0]             w_in_amask;
    logic                   w_in_illegal;
    logic                   w_in_is_read;
    logic                   w_in_access;
    logic [LANE_BITS-1:0]   w_in_lane;
    logic [STRB_WIDTH-1:0]  w_in_strobe;
    logic [DATA_WIDTH-1:0]  w_in_dmask;
    logic [DATA_WIDTH-1:0]  w_in_bus_data;
    logic [ADDR_WIDTH-1:0]  w_in_res_addr;
    logic [ADDR_WIDTH-1:0]  w_in_bus_addr;

    always_comb begin
        w_in_bytes    = 4'd1 << mem_size;
        w_in_amask    = 3'(w_in_bytes - 4'd1);
        w_in_illegal  = (w_in_bytes > c_STRB_BYTES) || (|(mem_addr[2:0] & w_in_amask));
        w_in_is_read  = mem_read & ~mem_write;
        w_in_access   = mem_read | mem_write;
        w_in_lane     = mem_addr[LANE_BITS-1:0];
        w_in_strobe   = '0;
        w_in_dmask    = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            w_in_strobe[b] = (b >= int'(w_in_lane)) &&
                             (b < int'(w_in_lane) + int'(w_in_bytes));
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_in_dmask[i] = (i < 8 * int'(w_in_bytes));
        end
        w_in_bus_data = (mem_data & w_in_dmask) << {w_in_lane, 3'b000};
        w_in_res_addr = (mem_is_pop && w_in_is_read) ?
                        (mem_addr + ADDR_WIDTH'(w_in_bytes)) : mem_addr;
        w_in_bus_addr = {mem_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
    end

    // Load-side alignment: lane shift, then a left/right shift pair that
    // both masks to the access size and performs sign/zero extension.
    logic [DATA_WIDTH-1:0]  w_rd_shift;
    logic [DATA_WIDTH-1:0]  w_rd_left;
    logic [DATA_WIDTH-1:0]  w_rd_ext;
    int                     w_rd_pad;

    always_comb begin
        w_rd_shift = data_bus_data_in >> {r_lane, 3'b000};
        w_rd_pad   = DATA_WIDTH - 8 * (1 << r_size);
        if (w_rd_pad < 0) begin
            w_rd_pad = 0;
        end
        w_rd_left  = w_rd_shift << w_rd_pad;
        if (r_signed) begin
            w_rd_ext = DATA_WIDTH'($signed(w_rd_left) >>> w_rd_pad);
        end else begin
            w_rd_ext = w_rd_left >> w_rd_pad;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_tmo_cnt           <= '0;
            r_write             <= 1'b0;
            r_signed            <= 1'b0;
            r_size              <= '0;
            r_lane              <= '0;
            r_res_addr          <= '0;
            r_user              <= '0;
            mem_ready           <= 1'b1;
            mem_output_valid    <= 1'b0;
            mem_data_out        <= '0;
            mem_addr_out        <= '0;
            mem_error           <= 1'b0;
            user_data_out       <= '0;
            data_bus_valid_out  <= 1'b0;
            data_bus_write_out  <= 1'b0;
            data_bus_read_out   <= 1'b0;
            data_bus_addr_out   <= '0;
            data_bus_data_out   <= '0;
            data_bus_strobe_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_valid_i) begin
                        mem_ready  <= 1'b0;
                        r_write    <= mem_write;
                        r_signed   <= mem_signed;
                        r_size     <= mem_size;
                        r_lane     <= w_in_lane;
                        r_res_addr <= w_in_res_addr;
                        r_user     <= user_data_in;
                        r_tmo_cnt  <= '0;
                        if (w_in_access && !w_in_illegal) begin
                            r_state             <= S_REQ;
                            data_bus_valid_out  <= 1'b1;
                            data_bus_write_out  <= mem_write;
                            data_bus_read_out   <= w_in_is_read;
                            data_bus_addr_out   <= w_in_bus_addr;
                            data_bus_data_out   <= w_in_bus_data;
                            data_bus_strobe_out <= w_in_strobe;
                        end else begin
                            // Pass-through or rejected access: no bus traffic
                            r_state          <= S_DONE;
                            mem_output_valid <= 1'b1;
                            mem_error        <= w_in_access & w_in_illegal;
                            mem_data_out     <= '0;
                            mem_addr_out     <= mem_addr;
                            user_data_out    <= user_data_in;
                        end
                    end
                end

                S_REQ, S_WAIT: begin
                    data_bus_valid_out  <= 1'b0;
                    data_bus_write_out  <= 1'b0;
                    data_bus_read_out   <= 1'b0;
                    data_bus_addr_out   <= '0;
                    data_bus_data_out   <= '0;
                    data_bus_strobe_out <= '0;
                    // A response coinciding with the timeout still completes cleanly
                    if (data_bus_valid_in) begin
                        r_state          <= S_DONE;
                        mem_output_valid <= 1'b1;
                        mem_error        <= 1'b0;
                        mem_data_out     <= r_write ? '0 : w_rd_ext;
                        mem_addr_out     <= r_res_addr;
                        user_data_out    <= r_user;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_tmo_cnt == c_TMO_LAST)) begin
                        r_state          <= S_DONE;
                        mem_output_valid <= 1'b1;
                        mem_error        <= 1'b1;
                        mem_data_out     <= '0;
                        mem_addr_out     <= r_res_addr;
                        user_data_out    <= r_user;
                    end else begin
                        r_state   <= S_WAIT;
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    if (mem_out_ready) begin
                        r_state          <= S_IDLE;
                        mem_ready        <= 1'b1;
                        mem_output_valid <= 1'b0;
                        mem_error        <= 1'b0;
                        mem_data_out     <= '0;
                        mem_addr_out     <= '0;
                        user_data_out    <= '0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    mem_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_w0rm_core_mem_stage.sv
// ============================================================================
// Module   : tb_w0rm_core_mem_stage
// Brief    : Vector-table bench with a result scoreboard for the memory stage.
// Revision : 2.0
// ============================================================================
`default_nettype none

module tb_w0rm_core_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_i;
    logic        mem_ready;
    logic        mem_write, mem_read, mem_is_pop, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  user_data_in;
    logic        mem_output_valid;
    logic        mem_out_ready;
    logic [31:0] mem_data_out, mem_addr_out;
    logic        mem_error;
    logic [1:0]  user_data_out;
    logic        data_bus_valid_out, data_bus_write_out, data_bus_read_out;
    logic [31:0] data_bus_addr_out, data_bus_data_out;
    logic [3:0]  data_bus_strobe_out;
    logic [31:0] data_bus_data_in;
    logic        data_bus_valid_in;

    w0rm_core_mem_stage #(
        .USER_WIDTH     (2),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_valid_i         (mem_valid_i),
        .mem_ready           (mem_ready),
        .mem_write           (mem_write),
        .mem_read            (mem_read),
        .mem_is_pop          (mem_is_pop),
        .mem_signed          (mem_signed),
        .mem_size            (mem_size),
        .mem_addr            (mem_addr),
        .mem_data            (mem_data),
        .user_data_in        (user_data_in),
        .mem_output_valid    (mem_output_valid),
        .mem_out_ready       (mem_out_ready),
        .mem_data_out        (mem_data_out),
        .mem_addr_out        (mem_addr_out),
        .mem_error           (mem_error),
        .user_data_out       (user_data_out),
        .data_bus_valid_out  (data_bus_valid_out),
        .data_bus_write_out  (data_bus_write_out),
        .data_bus_read_out   (data_bus_read_out),
        .data_bus_addr_out   (data_bus_addr_out),
        .data_bus_data_out   (data_bus_data_out),
        .data_bus_strobe_out (data_bus_strobe_out),
        .data_bus_data_in    (data_bus_data_in),
        .data_bus_valid_in   (data_bus_valid_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr, rd, pop, sgn;
        logic [1:0]  size;
        logic [31:0] addr, data;
        logic [1:0]  user;
        int          resp_k;      // response in cycle N+resp_k, 0 = never
        logic [31:0] rdata;
        int          hold;        // cycles mem_out_ready stays low
        logic        exp_bus;
        logic [31:0] exp_baddr, exp_bdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_dout, exp_aout;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] dout, aout;
        logic        err;
        logic [1:0]  user;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   j;
        bit   done;
        @(negedge clk);
        mem_write = v.wr; mem_read = v.rd; mem_is_pop = v.pop; mem_signed = v.sgn;
        mem_size = v.size; mem_addr = v.addr; mem_data = v.data; user_data_in = v.user;
        mem_valid_i = 1'b1;
        sb.push_back('{v.exp_dout, v.exp_aout, v.exp_err, v.user, v.exp_lat});
        chk($sformatf("v%0d ready_before", idx), 32'(mem_ready), 32'd1);
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        j = 0;
        done = 1'b0;
        while (!done && j < 20) begin
            if (j == 0) begin
                chk($sformatf("v%0d bus_valid", idx), 32'(data_bus_valid_out), 32'(v.exp_bus));
                if (v.exp_bus) begin
                    chk($sformatf("v%0d bus_addr", idx), data_bus_addr_out, v.exp_baddr);
                    chk($sformatf("v%0d bus_data", idx), data_bus_data_out, v.exp_bdata);
                    chk($sformatf("v%0d bus_strb", idx), 32'(data_bus_strobe_out), 32'(v.exp_strb));
                    chk($sformatf("v%0d bus_wr", idx), 32'(data_bus_write_out), 32'(v.wr));
                    chk($sformatf("v%0d bus_rd", idx), 32'(data_bus_read_out), 32'(v.rd & ~v.wr));
                end
            end
            if (mem_output_valid) begin
                done = 1'b1;
            end else begin
                if (j == 1) begin
                    chk($sformatf("v%0d bus_idle", idx), 32'(data_bus_valid_out), 32'd0);
                    chk($sformatf("v%0d bus_addr0", idx), data_bus_addr_out, 32'd0);
                end
                if (j + 1 == v.resp_k) begin
                    data_bus_valid_in = 1'b1;
                    data_bus_data_in  = v.rdata;
                end
                @(posedge clk); #1;
                data_bus_valid_in = 1'b0;
                j++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d no_output: got none expected valid within 20 cycles", idx);
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got output expected empty queue", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d latency", idx), 32'(j + 1), 32'(e.lat));
            for (int h = 0; h <= v.hold; h++) begin
                chk($sformatf("v%0d h%0d valid", idx, h), 32'(mem_output_valid), 32'd1);
                chk($sformatf("v%0d h%0d ready", idx, h), 32'(mem_ready), 32'd0);
                chk($sformatf("v%0d h%0d dout", idx, h), mem_data_out, e.dout);
                chk($sformatf("v%0d h%0d aout", idx, h), mem_addr_out, e.aout);
                chk($sformatf("v%0d h%0d err", idx, h), 32'(mem_error), 32'(e.err));
                chk($sformatf("v%0d h%0d user", idx, h), 32'(user_data_out), 32'(e.user));
                if (h == v.hold) mem_out_ready = 1'b1;
                @(posedge clk); #1;
            end
            mem_out_ready = 1'b0;
            chk($sformatf("v%0d ready_after", idx), 32'(mem_ready), 32'd1);
            chk($sformatf("v%0d valid_after", idx), 32'(mem_output_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wr rd pop sg sz  addr          data          us  k  rdata         hold bus baddr          bdata          strb   dout          aout          err lat
        vecs[0]  = '{0, 1, 0, 0, 2'd2, 32'h0000_0100, 32'h0,        2'd1, 1, 32'hDEADBEEF, 0, 1, 32'h0000_0100, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0000_0100, 0, 2};
        vecs[1]  = '{0, 1, 0, 1, 2'd0, 32'h0000_0103, 32'h0,        2'd2, 1, 32'h80123456, 1, 1, 32'h0000_0100, 32'h0,        4'h8, 32'hFFFFFF80, 32'h0000_0103, 0, 2};
        vecs[2]  = '{0, 1, 0, 0, 2'd0, 32'h0000_0103, 32'h0,        2'd3, 1, 32'h80123456, 0, 1, 32'h0000_0100, 32'h0,        4'h8, 32'h00000080, 32'h0000_0103, 0, 2};
        vecs[3]  = '{1, 0, 0, 0, 2'd1, 32'h0000_0202, 32'h0000ABCD, 2'd3, 2, 32'h0,        0, 1, 32'h0000_0200, 32'hABCD0000, 4'hC, 32'h0,        32'h0000_0202, 0, 3};
        vecs[4]  = '{0, 1, 1, 0, 2'd2, 32'h0000_01FC, 32'h0,        2'd0, 4, 32'h12345678, 0, 1, 32'h0000_01FC, 32'h0,        4'hF, 32'h12345678, 32'h0000_0200, 0, 5};
        vecs[5]  = '{0, 1, 0, 0, 2'd2, 32'h0000_0101, 32'h0,        2'd1, 0, 32'h0,        0, 0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_0101, 1, 1};
        vecs[6]  = '{0, 1, 0, 0, 2'd2, 32'h0000_0040, 32'h0,        2'd2, 0, 32'h0,        0, 1, 32'h0000_0040, 32'h0,        4'hF, 32'h0,        32'h0000_0040, 1, 5};
        vecs[7]  = '{0, 0, 1, 0, 2'd2, 32'h0000_0055, 32'h0,        2'd3, 0, 32'h0,        1, 0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_0055, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 2'd3, 32'h0000_0000, 32'h0,        2'd0, 0, 32'h0,        0, 0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_0000, 1, 1};
        vecs[9]  = '{1, 1, 1, 0, 2'd0, 32'h0000_0001, 32'hFFFFFF5A, 2'd1, 1, 32'h0,        3, 1, 32'h0000_0000, 32'h00005A00, 4'h2, 32'h0,        32'h0000_0001, 0, 2};
        vecs[10] = '{0, 1, 0, 1, 2'd1, 32'h0000_0002, 32'h0,        2'd2, 3, 32'h80017FFF, 0, 1, 32'h0000_0000, 32'h0,        4'hC, 32'hFFFF8001, 32'h0000_0002, 0, 4};
        vecs[11] = '{0, 1, 1, 0, 2'd0, 32'hFFFF_FFFF, 32'h0,        2'd2, 1, 32'hAB000000, 0, 1, 32'hFFFF_FFFC, 32'h0,        4'h8, 32'h000000AB, 32'h0000_0000, 0, 2};
        vecs[12] = '{0, 1, 0, 1, 2'd0, 32'h0000_0001, 32'h0,        2'd1, 2, 32'h00007F00, 0, 1, 32'h0000_0000, 32'h0,        4'h2, 32'h0000007F, 32'h0000_0001, 0, 3};

        reset = 1'b1; mem_valid_i = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        mem_is_pop = 1'b0; mem_signed = 1'b0; mem_size = 2'd0; mem_addr = '0;
        mem_data = '0; user_data_in = '0; mem_out_ready = 1'b0;
        data_bus_data_in = '0; data_bus_valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 32'(mem_ready), 32'd1);
        chk("rst valid", 32'(mem_output_valid), 32'd0);
        chk("rst dout", mem_data_out, 32'd0);
        chk("rst aout", mem_addr_out, 32'd0);
        chk("rst err", 32'(mem_error), 32'd0);
        chk("rst bus_valid", 32'(data_bus_valid_out), 32'd0);
        chk("rst bus_strb", 32'(data_bus_strobe_out), 32'd0);
        reset = 1'b0;

        // Stray response while idle must be dropped
        @(negedge clk);
        data_bus_valid_in = 1'b1;
        data_bus_data_in  = 32'h5555AAAA;
        @(posedge clk); #1;
        data_bus_valid_in = 1'b0;
        chk("stray valid", 32'(mem_output_valid), 32'd0);
        chk("stray ready", 32'(mem_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while waiting on the bus, followed by a late response
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; mem_is_pop = 1'b1; mem_signed = 1'b0;
        mem_size = 2'd2; mem_addr = 32'h0000_0300; user_data_in = 2'd3;
        mem_valid_i = 1'b1;
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        chk("rstw req", 32'(data_bus_valid_out), 32'd1);
        @(posedge clk); #1;
        chk("rstw waiting", 32'(mem_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        data_bus_valid_in = 1'b1;
        data_bus_data_in  = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_bus_valid_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rstw c%0d ready", c), 32'(mem_ready), 32'd1);
            chk($sformatf("rstw c%0d valid", c), 32'(mem_output_valid), 32'd0);
            chk($sformatf("rstw c%0d dout", c), mem_data_out, 32'd0);
            chk($sformatf("rstw c%0d aout", c), mem_addr_out, 32'd0);
            chk($sformatf("rstw c%0d err", c), 32'(mem_error), 32'd0);
            chk($sformatf("rstw c%0d user", c), 32'(user_data_out), 32'd0);
            chk($sformatf("rstw c%0d bus", c), 32'(data_bus_valid_out), 32'd0);
            @(posedge clk); #1;
        end

        // Stage still works normally after the mid-flight reset
        run_vec(13, vecs[0]);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/w0rm_core_mem_stage.md
# w0rm_core_mem_stage

Second-generation W0RM memory pipeline stage, sitting between execute and writeback and bridging to the single-master data bus. It adds four things to the single-word stage it supersedes:
- sub-word access sizes with byte strobes and sign extension on loads;
- stack-pop address post-increment;
- a bus timeout with error reporting;
- a ready/valid output handshake so writeback can stall the stage.

It holds at most one transaction at a time.

## Interface
Parameters:
- USER_WIDTH, 1, sideband bits carried unchanged from input to output.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, bus and data width. Legal values are 16, 32 and 64. LANE_BITS = log2(DATA_WIDTH/8).
- TIMEOUT_CYCLES, 16, bus response timeout. 0 disables the timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mem_valid_i  in  1  input transaction valid.
- mem_ready  out  1  stage can accept; high only in IDLE.
- mem_write, mem_read, mem_is_pop, mem_signed  in  1 each  op controls.
- mem_size  in  2  log2 of access bytes (0=byte, 1=half, 2=word, 3=dword).
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_data  in  DATA_WIDTH  store data, right-justified.
- user_data_in  in  USER_WIDTH  sideband.
- mem_output_valid  out  1  result valid, held until accepted.
- mem_out_ready  in  1  downstream accepts the result.
- mem_data_out  out  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 otherwise.
- mem_addr_out  out  ADDR_WIDTH  post-increment address on a pop, else mem_addr.
- mem_error  out  1  misaligned access, illegal size, or timeout.
- user_data_out  out  USER_WIDTH  sideband.
- data_bus_valid_out, data_bus_write_out, data_bus_read_out  out  1 each  bus request.
- data_bus_addr_out  out  ADDR_WIDTH  mem_addr with the low LANE_BITS bits cleared.
- data_bus_data_out  out  DATA_WIDTH  store data shifted to its byte lane.
- data_bus_strobe_out  out  DATA_WIDTH/8  byte enables.
- data_bus_data_in  in  DATA_WIDTH  read data.
- data_bus_valid_in  in  1  bus response.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**, on mem_valid_i (mem_ready is high in IDLE): all inputs are registered.
  - If neither read nor write, or if 2^mem_size > DATA_WIDTH/8 or mem_addr mod 2^mem_size != 0: go to DONE. mem_error is set when the check failed. There is no bus activity.
  - Otherwise go to REQ.
  - If both mem_write and mem_read are set, write wins.
- **REQ**: data_bus_valid_out = 1 for exactly this one cycle.
  - Byte lane = mem_addr[LANE_BITS-1:0].
  - Strobe = (2^(2^size) - 1) shifted left by lane. Read requests also drive the strobe.
  - Bus data = (mem_data & low 8·2^size bits mask) shifted left by 8·lane.
  - A data_bus_valid_in in this cycle completes the transaction and goes to DONE. Otherwise go to WAIT.
- **WAIT**: stay until data_bus_valid_in, then go to DONE.
  - On a read, the captured data is shifted right by 8·lane and masked to the access size.
  - If mem_signed is set, the result is sign-extended from its top bit; otherwise it is zero-extended.
  - On a write, mem_data_out = 0.
- **Pop** (mem_is_pop with a read): mem_addr_out = mem_addr + 2^size, wrapping modulo 2^ADDR_WIDTH. mem_is_pop is ignored on writes and pass-throughs.
- **Timeout**: a counter counts the cycles spent in REQ and WAIT.
  - If no response arrives within TIMEOUT_CYCLES cycles, go to DONE with mem_error = 1 and mem_data_out = 0.
  - A response arriving in the same cycle as the timeout wins: mem_error = 0.
- **DONE**: mem_output_valid = 1, with all result outputs stable. Return to IDLE on the cycle mem_out_ready = 1.
- data_bus_valid_in is ignored in IDLE and DONE. Stray responses are dropped.
- While data_bus_valid_out = 0, the bus write/read/addr/data/strobe outputs are 0.
- **Reset**, whether asserted mid-operation or otherwise: the state goes to IDLE and the timeout counter clears.
  - Outputs after reset: mem_ready = 1; every other output = 0.
  - A bus response arriving after reset is ignored.

## Timing
- Accept at edge N. Request visible in cycle N+1.
- Fastest load or store completes with mem_output_valid high from edge N+2. That is a response in cycle N+1 and mem_out_ready = 1.
- Pass-through, misaligned and illegal-size accesses have mem_output_valid high from edge N+1.
- A response in cycle N+k (k≥1) gives output valid from edge N+k+1.
- Timeout gives output valid from edge N+TIMEOUT_CYCLES+1.
- Back-to-back throughput: one transaction per 2 cycles for pass-through, 3 cycles minimum for bus operations.
- mem_ready is low from edge N until the edge after the DONE handshake. There is no same-cycle re-accept.

## Test plan
- Word load, DATA_WIDTH=32, addr 0x100, bus returns 0xDEADBEEF in the REQ cycle:
  - bus addr 0x100, strobe 0xF;
  - mem_data_out 0xDEADBEEF at N+2, mem_error 0.
- Signed byte load at 0x103, bus data 0x80123456:
  - strobe 0x8;
  - mem_data_out 0xFFFFFF80. Unsigned gives 0x00000080.
- Half store of 0x0000ABCD at 0x202:
  - bus addr 0x200, data 0xABCD0000, strobe 0xC;
  - mem_data_out 0.
- Word pop at 0x1FC, response after 3 wait cycles:
  - mem_addr_out 0x200;
  - output valid at N+5.
- Misaligned word access at 0x101:
  - no bus request;
  - mem_error 1 at N+1.
- Further cases:
  - Timeout, TIMEOUT_CYCLES=4 with no response: mem_error 1 at N+5.
  - mem_out_ready held low 3 cycles: outputs stable and mem_ready 0 throughout.
  - reset asserted in WAIT followed by a late response: back in IDLE with all outputs 0.
